// File: rtl/reg_pipeline_pkg.sv
// Shared constants for the elastic register pipeline: default geometry and the
// occupancy-counter width helper used by the RTL and by benches.
package reg_pipeline_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 3;

  // Bits needed to count 0..depth valid stages.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipeline_stage.sv
// One stage of the elastic pipeline: a valid bit plus a data word that loads
// from the previous stage whenever the stage is allowed to advance.
module reg_pipeline_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (adv) begin
      valid <= prev_valid;
      // A bubble moving through leaves the old data word in place.
      if (prev_valid) data <= prev_data;
    end
  end

endmodule

// File: rtl/reg_pipeline.sv
// DEPTH-stage elastic register pipeline with valid/ready on both sides,
// global hold (enable), synchronous flush and a registered occupancy count.
module reg_pipeline
  import reg_pipeline_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter int               DEPTH     = DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_next;

  // The recursive ready chain unrolls to: stage i may advance if any stage at or
  // after i is empty, or the consumer is taking the last word. Walking from the
  // output end with an accumulator avoids a self-referencing vector.
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room   = room | ~v[i];
      adv[i] = enable & room;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v[DEPTH-1] & enable & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      reg_pipeline_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .adv        (adv[i]),
        .prev_valid (in_valid),
        .prev_data  (in_data),
        .valid      (v[i]),
        .data       (d[i])
      );
    end else begin : g_next
      reg_pipeline_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .adv        (adv[i]),
        .prev_valid (v[i-1]),
        .prev_data  (d[i-1]),
        .valid      (v[i]),
        .data       (d[i])
      );
    end
  end

  // Internal moves conserve the number of valid words, so occupancy only
  // changes through the two boundary transfers.
  always_comb begin
    count_next = count;
    if (in_xfer && !out_xfer)      count_next = count + CNT_W'(1);
    else if (!in_xfer && out_xfer) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) count <= '0;
    else                 count <= count_next;
  end

endmodule

// File: tb/tb_reg_pipeline.sv
// Self-checking bench for reg_pipeline (WIDTH=8, DEPTH=3): vector table for
// handshake/occupancy plus a scoreboard that checks data order and count.
module tb_reg_pipeline;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] sb_q[$];
  bit         reset_seen = 1'b0;

  reg_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: count must equal words in flight; every output word must match
  // the oldest accepted input.
  always @(negedge clk) begin
    if (reset_seen) check("count_vs_scoreboard", 32'(count), 32'(sb_q.size()));
    if (!rst_n) begin
      reset_seen = 1'b1;
      sb_q.delete();
    end else if (flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        else check("out_data_order", 32'(out_data), 32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  // Drive one cycle's inputs just after the rising edge; return at the falling edge.
  task automatic next_cycle(input logic rst, input logic en, input logic fl,
                            input logic iv, input logic [7:0] dat, input logic ordy);
    @(posedge clk);
    #1;
    rst_n = rst; enable = en; flush = fl;
    in_valid = iv; in_data = dat; out_ready = ordy;
    @(negedge clk);
  endtask

  typedef struct {
    bit       en;
    bit       fl;
    bit       iv;
    bit [7:0] d;
    bit       ordy;
    bit       exp_rdy;
    bit       exp_ov;
    bit [1:0] exp_cnt;
  } vec_t;

  vec_t vecs[19];

  initial begin
    //        en fl iv d      or  rdy ov cnt
    vecs = '{
      '{1, 0, 1, 8'hA0, 0, 1, 0, 2'd0},   // fill under stall
      '{1, 0, 1, 8'hA1, 0, 1, 0, 2'd1},
      '{1, 0, 1, 8'hA2, 0, 1, 0, 2'd2},
      '{1, 0, 1, 8'hA3, 0, 0, 1, 2'd3},   // full: fourth word refused
      '{0, 0, 1, 8'hA3, 1, 0, 0, 2'd3},   // hold while full
      '{1, 0, 0, 8'h00, 1, 1, 1, 2'd3},   // drain A0
      '{0, 0, 0, 8'h00, 1, 0, 0, 2'd2},   // hold with 2 inside
      '{0, 0, 0, 8'h00, 1, 0, 0, 2'd2},
      '{1, 0, 0, 8'h00, 1, 1, 1, 2'd2},   // A1
      '{1, 0, 0, 8'h00, 1, 1, 1, 2'd1},   // A2
      '{1, 0, 0, 8'h00, 1, 1, 0, 2'd0},
      '{1, 0, 1, 8'hB0, 0, 1, 0, 2'd0},   // bubble compression
      '{1, 0, 0, 8'h00, 0, 1, 0, 2'd1},
      '{1, 0, 0, 8'h00, 0, 1, 0, 2'd1},
      '{1, 0, 1, 8'hB1, 0, 1, 1, 2'd1},   // empty stage accepts under stall
      '{1, 0, 0, 8'h00, 1, 1, 1, 2'd2},   // B0 out
      '{1, 0, 0, 8'h00, 1, 1, 0, 2'd1},
      '{1, 0, 0, 8'h00, 1, 1, 1, 2'd1},   // B1 out
      '{1, 0, 0, 8'h00, 1, 1, 0, 2'd0}
    };

    // Reset held for two edges.
    next_cycle(0, 1, 0, 0, 8'h00, 1);
    next_cycle(0, 1, 0, 0, 8'h00, 1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Streaming latency: words appear three cycles after their input cycle.
    begin
      logic [7:0] words [3];
      words = '{8'hC1, 8'h01, 8'h7F};
      for (int t = 0; t < 6; t++) begin
        if (t < 3) next_cycle(1, 1, 0, 1, words[t], 1);
        else       next_cycle(1, 1, 0, 0, 8'h00, 1);
        check("lat_out_valid", 32'(out_valid), (t >= 3) ? 32'd1 : 32'd0);
        if (t >= 3) check("lat_out_data", 32'(out_data), 32'(words[t-3]));
        if (t == 3) check("lat_count_peak", 32'(count), 32'd3);
      end
    end

    // Backpressure, hold and bubble compression from the vector table.
    foreach (vecs[k]) begin
      next_cycle(1, vecs[k].en, vecs[k].fl, vecs[k].iv, vecs[k].d, vecs[k].ordy);
      check($sformatf("vec%0d_in_ready", k),  32'(in_ready),  32'(vecs[k].exp_rdy));
      check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
      check($sformatf("vec%0d_count", k),     32'(count),     32'(vecs[k].exp_cnt));
    end

    // Flush with three words inside, enable low during the flush cycle.
    next_cycle(1, 1, 0, 1, 8'hE0, 0);
    next_cycle(1, 1, 0, 1, 8'hE1, 0);
    next_cycle(1, 1, 0, 1, 8'hE2, 0);
    next_cycle(1, 0, 1, 1, 8'hE3, 1);
    check("flush_count_before", 32'(count),     32'd3);
    check("flush_in_ready",     32'(in_ready),  32'd0);
    check("flush_out_valid",    32'(out_valid), 32'd0);
    next_cycle(1, 1, 0, 1, 8'hD0, 1);
    check("post_flush_count",     32'(count),     32'd0);
    check("post_flush_out_valid", 32'(out_valid), 32'd0);
    for (int t = 1; t <= 3; t++) begin
      next_cycle(1, 1, 0, 0, 8'h00, 1);
      check("post_flush_lat_valid", 32'(out_valid), (t == 3) ? 32'd1 : 32'd0);
      if (t == 3) check("post_flush_lat_data", 32'(out_data), 32'hD0);
    end
    next_cycle(1, 1, 0, 0, 8'h00, 1);

    // Reset asserted during a back-pressured stall.
    next_cycle(1, 1, 0, 1, 8'hF0, 0);
    next_cycle(1, 1, 0, 1, 8'hF1, 0);
    next_cycle(1, 1, 0, 1, 8'hF2, 0);
    next_cycle(1, 1, 0, 1, 8'hF3, 0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_count",    32'(count),    32'd3);
    next_cycle(0, 1, 0, 1, 8'hF3, 1);
    next_cycle(1, 1, 0, 0, 8'h00, 1);
    check("midrst_count",     32'(count),     32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'h00);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    for (int t = 0; t < 4; t++) begin
      next_cycle(1, 1, 0, 0, 8'h00, 1);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
